// File: rtl/byte_entry_ctrl_pkg.sv
// Shared types and constants for the byte entry controller.
package byte_entry_ctrl_pkg;

    // Entry FSM state encoding
    typedef enum logic [1:0] {
        LOAD_LO = 2'b00,
        LOAD_HI = 2'b01,
        OFFER   = 2'b10
    } entry_state_t;

    // Default number of stable synchronized cycles for debounce acceptance
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage : byte_entry_ctrl_pkg

// File: rtl/byte_entry_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Accept a level change only after it has been stable long enough;
    // the press pulse is registered alongside the 0->1 level update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : btn_debounce

// File: rtl/byte_entry_ctrl.sv
// Two-press nibble entry from DIP switches into a byte offered downstream
// with a valid/ready handshake and a sticky overrun flag.
module byte_entry_ctrl
    import byte_entry_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dip_switch,
    input  logic       shift_btn,
    input  logic       cs,
    input  logic       byte_ready,
    input  logic       overrun_clr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       phase_hi,
    output logic       overrun
);

    entry_state_t state;
    logic         press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(shift_btn),
        .press  (press)
    );

    // Entry FSM with registered outputs; a press while a byte is pending
    // sets overrun, which takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_LO;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            phase_hi   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            unique case (state)
                LOAD_LO: begin
                    if (press && !cs) begin
                        byte_out[3:0] <= dip_switch;
                        state         <= LOAD_HI;
                        phase_hi      <= 1'b1;
                    end
                end
                LOAD_HI: begin
                    if (cs) begin
                        state    <= LOAD_LO;
                        phase_hi <= 1'b0;
                    end else if (press) begin
                        byte_out[7:4] <= dip_switch;
                        state         <= OFFER;
                        phase_hi      <= 1'b0;
                        byte_valid    <= 1'b1;
                    end
                end
                OFFER: begin
                    if (press) begin
                        overrun <= 1'b1;
                    end
                    if (byte_ready) begin
                        state      <= LOAD_LO;
                        byte_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= LOAD_LO;
                    phase_hi   <= 1'b0;
                    byte_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : byte_entry_ctrl

// File: tb/tb_byte_entry_ctrl.sv
// Scoreboard bench for byte_entry_ctrl with a short debounce window.
module tb_byte_entry_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] dip_switch;
    logic       shift_btn;
    logic       cs;
    logic       byte_ready;
    logic       overrun_clr;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       phase_hi;
    logic       overrun;

    int n_checks;
    int n_fail;
    int valid_cycles;
    int phase_rises;

    logic [7:0] exp_q[$];

    byte_entry_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dip_switch (dip_switch),
        .shift_btn  (shift_btn),
        .cs         (cs),
        .byte_ready (byte_ready),
        .overrun_clr(overrun_clr),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .phase_hi   (phase_hi),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clean press/release of the shift button with the given nibble on the DIPs
    task automatic press_nib(input logic [3:0] nib);
        dip_switch = nib;
        shift_btn  = 1'b1;
        tick(10);
        shift_btn  = 1'b0;
        tick(10);
    endtask

    // Monitor: scoreboard pop on handshake, hold check while stalled, event counters
    initial begin : monitor
        logic       pend;
        logic [7:0] pend_byte;
        logic       prev_phase;
        pend       = 1'b0;
        pend_byte  = 8'h00;
        prev_phase = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend       = 1'b0;
                prev_phase = 1'b0;
            end else begin
                if (pend) begin
                    check("valid_held", {31'd0, byte_valid}, 32'd1);
                    check("byte_held", {24'd0, byte_out}, {24'd0, pend_byte});
                end
                if (byte_valid) valid_cycles++;
                if (phase_hi && !prev_phase) phase_rises++;
                prev_phase = phase_hi;
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
                    end else begin
                        check("byte_accepted", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
                    end
                end
                pend      = byte_valid && !byte_ready;
                pend_byte = byte_out;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_checks     = 0;
        n_fail       = 0;
        valid_cycles = 0;
        phase_rises  = 0;
        rst_n        = 1'b0;
        dip_switch   = 4'h0;
        shift_btn    = 1'b0;
        cs           = 1'b0;
        byte_ready   = 1'b0;
        overrun_clr  = 1'b0;

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_byte_out", {24'd0, byte_out}, 32'h00);
        check("rst_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_phase", {31'd0, phase_hi}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Clean entry with downstream always ready
        byte_ready   = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(8'h5A);
        press_nib(4'hA);
        @(negedge clk);
        check("clean_phase_hi", {31'd0, phase_hi}, 32'd1);
        press_nib(4'h5);
        @(negedge clk);
        check("clean_valid_cycles", valid_cycles, 32'd1);
        check("clean_back_lo", {31'd0, phase_hi}, 32'd0);
        check("clean_q_empty", exp_q.size(), 32'd0);

        // Bouncing button yields exactly one press
        byte_ready  = 1'b0;
        phase_rises = 0;
        dip_switch  = 4'hC;
        for (int i = 0; i < 10; i++) begin
            shift_btn = ~shift_btn;
            tick(2);
        end
        dip_switch = 4'hC;
        shift_btn  = 1'b1;
        tick(15);
        @(negedge clk);
        check("bounce_one_press", phase_rises, 32'd1);
        check("bounce_phase_hi", {31'd0, phase_hi}, 32'd1);
        check("bounce_low_nibble", {28'd0, byte_out[3:0]}, 32'hC);
        shift_btn = 1'b0;
        tick(12);

        // Backpressure: byte 3C pending while extra presses arrive
        exp_q.push_back(8'h3C);
        press_nib(4'h3);
        @(negedge clk);
        check("bp_valid", {31'd0, byte_valid}, 32'd1);
        check("bp_byte", {24'd0, byte_out}, 32'h3C);
        check("bp_no_overrun", {31'd0, overrun}, 32'd0);
        press_nib(4'h7);
        press_nib(4'h8);
        tick(10);
        @(negedge clk);
        check("bp_overrun", {31'd0, overrun}, 32'd1);
        check("bp_still_valid", {31'd0, byte_valid}, 32'd1);
        check("bp_still_byte", {24'd0, byte_out}, 32'h3C);
        @(posedge clk);
        #1;
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("bp_overrun_clr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        @(negedge clk);
        check("bp_accepted", {31'd0, byte_valid}, 32'd0);
        check("bp_q_empty", exp_q.size(), 32'd0);

        // Chip-select abort in LOAD_HI, then a fresh entry
        byte_ready = 1'b1;
        press_nib(4'h7);
        @(negedge clk);
        check("cs_lo_captured", {31'd0, phase_hi}, 32'd1);
        @(posedge clk);
        #1;
        cs = 1'b1;
        tick(1);
        @(negedge clk);
        check("cs_abort_phase", {31'd0, phase_hi}, 32'd0);
        press_nib(4'h9);
        @(negedge clk);
        check("cs_ignored_phase", {31'd0, phase_hi}, 32'd0);
        check("cs_ignored_valid", {31'd0, byte_valid}, 32'd0);
        check("cs_no_capture", {24'd0, byte_out}, 32'h37);
        cs = 1'b0;
        exp_q.push_back(8'h21);
        press_nib(4'h1);
        press_nib(4'h2);
        @(negedge clk);
        check("cs_q_empty", exp_q.size(), 32'd0);
        check("cs_byte_out", {24'd0, byte_out}, 32'h21);
        check("cs_valid_low", {31'd0, byte_valid}, 32'd0);

        // Asynchronous reset mid-entry
        byte_ready = 1'b0;
        press_nib(4'h4);
        @(negedge clk);
        check("mid_phase_hi", {31'd0, phase_hi}, 32'd1);
        check("mid_byte_out", {24'd0, byte_out}, 32'h24);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_byte_out", {24'd0, byte_out}, 32'h00);
        check("async_valid", {31'd0, byte_valid}, 32'd0);
        check("async_phase", {31'd0, phase_hi}, 32'd0);
        check("async_overrun", {31'd0, overrun}, 32'd0);

        // Button held through reset release gives one press
        dip_switch = 4'hE;
        shift_btn  = 1'b1;
        tick(3);
        phase_rises = 0;
        rst_n       = 1'b1;
        tick(15);
        @(negedge clk);
        check("held_one_press", phase_rises, 32'd1);
        check("held_byte_out", {24'd0, byte_out}, 32'h0E);
        shift_btn = 1'b0;
        tick(12);
        @(negedge clk);
        check("held_no_repeat", phase_rises, 32'd1);
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_byte_entry_ctrl
